// File: rtl/sie_tx_packetizer.sv
// SIE transmit packetizer: turns token, handshake, SOF and data requests into a
// UTMI byte stream, appending CRC5 to tokens/SOF and CRC16 to data payloads.
module sie_tx_packetizer #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        SIE_clk,
  input  logic        rst,
  input  logic [7:0]  PID,
  input  logic [6:0]  device_address,
  input  logic [3:0]  endpoint_address,
  input  logic [6:0]  data_length,
  input  logic        PID_ready,
  input  logic        send_SOF_packet,
  input  logic [10:0] frame_num_SIE,
  input  logic [7:0]  tx_sie_data,
  input  logic        tx_fifo_empty,
  output logic        tx_fifo_r_en,
  output logic [7:0]  utmi_tx_data,
  output logic        utmi_tx_valid,
  input  logic        utmi_tx_ready,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_underrun,
  output logic        req_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOK1, S_TOK2, S_DATA, S_CRC_LO, S_CRC_HI, S_DONE
  } state_t;

  typedef enum logic [1:0] {C_TOKEN, C_HAND, C_DATA} class_t;

  localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

  function automatic logic [4:0] crc5_calc(input logic [10:0] field);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ field[i]) c = (c >> 1) ^ 5'h14;
      else                 c = c >> 1;
    end
    return ~c;
  endfunction

  // Running register is kept un-inverted; inversion happens when the CRC bytes go out.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  class_t      cls_q, cls_d;
  logic [7:0]  pid_q, pid_d;
  logic [15:0] field_q, field_d;
  logic [6:0]  rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  byte_q, byte_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  logic        pid_ok;
  class_t      pid_cls;
  logic        in_data;
  logic        accept;
  logic        req_any;

  always_comb begin
    pid_ok  = 1'b0;
    pid_cls = C_TOKEN;
    if (PID[7:4] == ~PID[3:0]) begin
      case (PID[3:0])
        4'b0001, 4'b1001, 4'b1101: begin pid_ok = 1'b1; pid_cls = C_TOKEN; end
        4'b0011, 4'b1011:          begin pid_ok = 1'b1; pid_cls = C_DATA;  end
        4'b0010, 4'b1010, 4'b1110: begin pid_ok = 1'b1; pid_cls = C_HAND;  end
        default: ;
      endcase
    end
  end

  // Payload bytes stream straight from the FIFO head; all other bytes come from byte_q.
  assign in_data       = (state_q == S_DATA);
  assign utmi_tx_valid = in_data ? ~tx_fifo_empty : vld_q;
  assign utmi_tx_data  = in_data ? tx_sie_data : byte_q;
  assign accept        = utmi_tx_valid & utmi_tx_ready;
  assign tx_fifo_r_en  = in_data & accept;
  assign tx_underrun   = in_data & tx_fifo_empty;
  assign busy          = busy_q;
  assign tx_done       = done_q;
  assign req_overrun   = ovr_q;
  assign req_any       = PID_ready | send_SOF_packet;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    pid_d   = pid_q;
    field_d = field_q;
    rem_d   = rem_q;
    crc_d   = crc_q;
    ovr_d   = (state_q != S_IDLE) & req_any;

    case (state_q)
      S_IDLE: begin
        crc_d = 16'hFFFF;
        if (send_SOF_packet) begin
          state_d = S_PID;
          cls_d   = C_TOKEN;
          pid_d   = 8'hA5;
          field_d = {crc5_calc(frame_num_SIE), frame_num_SIE};
          ovr_d   = PID_ready;
        end else if (PID_ready && pid_ok) begin
          state_d = S_PID;
          cls_d   = pid_cls;
          pid_d   = PID;
          field_d = {crc5_calc({endpoint_address, device_address}),
                     endpoint_address, device_address};
          rem_d   = (data_length > MAX_LEN) ? MAX_LEN : data_length;
        end
      end
      S_PID: begin
        if (accept) begin
          case (cls_q)
            C_TOKEN: state_d = S_TOK1;
            C_HAND:  state_d = S_DONE;
            default: state_d = (rem_q == 7'd0) ? S_CRC_LO : S_DATA;
          endcase
        end
      end
      S_TOK1: if (accept) state_d = S_TOK2;
      S_TOK2: if (accept) state_d = S_DONE;
      S_DATA: begin
        if (tx_fifo_empty) begin
          state_d = S_IDLE;
        end else if (accept) begin
          crc_d = crc16_byte(crc_q, tx_sie_data);
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: if (accept) state_d = S_CRC_HI;
      S_CRC_HI: if (accept) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    vld_d  = 1'b1;
    byte_d = 8'h00;
    case (state_d)
      S_PID:    byte_d = pid_d;
      S_TOK1:   byte_d = field_d[7:0];
      S_TOK2:   byte_d = field_d[15:8];
      S_CRC_LO: byte_d = ~crc_d[7:0];
      S_CRC_HI: byte_d = ~crc_d[15:8];
      default:  vld_d  = 1'b0;
    endcase
  end

  always_ff @(posedge SIE_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_TOKEN;
      pid_q   <= 8'h00;
      field_q <= 16'h0000;
      rem_q   <= 7'd0;
      crc_q   <= 16'hFFFF;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      pid_q   <= pid_d;
      field_q <= field_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_sie_tx_packetizer.sv
// Scoreboard bench for sie_tx_packetizer: directed packets from the test plan plus
// randomized requests checked against a bit-serial CRC reference model.
module tb_sie_tx_packetizer;

  logic        SIE_clk;
  logic        rst;
  logic [7:0]  PID;
  logic [6:0]  device_address;
  logic [3:0]  endpoint_address;
  logic [6:0]  data_length;
  logic        PID_ready;
  logic        send_SOF_packet;
  logic [10:0] frame_num_SIE;
  logic [7:0]  tx_sie_data;
  logic        tx_fifo_empty;
  logic        tx_fifo_r_en;
  logic [7:0]  utmi_tx_data;
  logic        utmi_tx_valid;
  logic        utmi_tx_ready;
  logic        busy;
  logic        tx_done;
  logic        tx_underrun;
  logic        req_overrun;

  sie_tx_packetizer #(.MAX_PAYLOAD(64)) dut (
    .SIE_clk(SIE_clk), .rst(rst), .PID(PID), .device_address(device_address),
    .endpoint_address(endpoint_address), .data_length(data_length),
    .PID_ready(PID_ready), .send_SOF_packet(send_SOF_packet),
    .frame_num_SIE(frame_num_SIE), .tx_sie_data(tx_sie_data),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_r_en(tx_fifo_r_en),
    .utmi_tx_data(utmi_tx_data), .utmi_tx_valid(utmi_tx_valid),
    .utmi_tx_ready(utmi_tx_ready), .busy(busy), .tx_done(tx_done),
    .tx_underrun(tx_underrun), .req_overrun(req_overrun)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, under_cnt = 0, ovr_cnt = 0, pop_cnt = 0;
  int rdy_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fifo[$];

  initial begin
    SIE_clk = 1'b0;
    forever #5 SIE_clk = ~SIE_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRCs in the non-reflected MSB-first form, reflected back at the end.
  function automatic logic [4:0] ref_crc5(input logic [10:0] f);
    logic [4:0] r = 5'h1F;
    logic [4:0] o;
    logic fb;
    for (int k = 0; k < 11; k++) begin
      fb = r[4] ^ f[k];
      r = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'b00101;
    end
    for (int k = 0; k < 5; k++) o[k] = r[4-k];
    return ~o;
  endfunction

  function automatic logic [15:0] ref_crc16(input logic [7:0] d[$]);
    logic [15:0] r = 16'hFFFF;
    logic [15:0] o;
    logic fb;
    foreach (d[j]) begin
      for (int k = 0; k < 8; k++) begin
        fb = r[15] ^ d[j][k];
        r = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int k = 0; k < 16; k++) o[k] = r[15-k];
    return ~o;
  endfunction

  // 0 = ignored, 1 = token, 2 = data, 3 = handshake
  function automatic int ref_class(input logic [7:0] p);
    case (p)
      8'hE1, 8'h69, 8'h2D: return 1;
      8'hC3, 8'h4B:        return 2;
      8'hD2, 8'h5A, 8'h1E: return 3;
      default:             return 0;
    endcase
  endfunction

  // FIFO model: show-ahead head, popped after the edge that accepted a read.
  initial begin
    logic pend;
    tx_fifo_empty = 1'b1;
    tx_sie_data   = 8'h00;
    forever begin
      @(negedge SIE_clk);
      pend = tx_fifo_r_en;
      @(posedge SIE_clk);
      #1;
      if (pend && fifo.size() > 0) void'(fifo.pop_front());
      tx_fifo_empty = (fifo.size() == 0);
      tx_sie_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
    end
  end

  initial begin
    utmi_tx_ready = 1'b1;
    forever begin
      @(posedge SIE_clk);
      #1;
      case (rdy_mode)
        0:       utmi_tx_ready = 1'b1;
        1:       utmi_tx_ready = ~utmi_tx_ready;
        default: utmi_tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every accepted byte is popped from the scoreboard and compared.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge SIE_clk);
      if (!rst) begin
        if (utmi_tx_valid && utmi_tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", utmi_tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", utmi_tx_data, e);
          end
        end
        if (tx_done) begin
          done_cnt++;
          check("done_valid_low", utmi_tx_valid, 1'b0);
        end
        if (tx_underrun) under_cnt++;
        if (req_overrun) ovr_cnt++;
        if (tx_fifo_r_en) pop_cnt++;
      end
    end
  end

  task automatic push_hex(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic issue(input bit sof, input bit pidr, input logic [7:0] pid,
                       input logic [6:0] addr, input logic [3:0] endp,
                       input logic [6:0] len, input logic [10:0] frame, input bit start);
    @(posedge SIE_clk);
    #1;
    PID = pid; device_address = addr; endpoint_address = endp;
    data_length = len; frame_num_SIE = frame;
    send_SOF_packet = sof; PID_ready = pidr;
    @(posedge SIE_clk);
    #1;
    send_SOF_packet = 1'b0; PID_ready = 1'b0;
    PID = 8'($urandom); device_address = 7'($urandom); endpoint_address = 4'($urandom);
    data_length = 7'($urandom); frame_num_SIE = 11'($urandom);
    check("start_busy", busy, start);
    check("start_valid", utmi_tx_valid, start);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(posedge SIE_clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=%0d pending=%0d expected idle", name, busy, exp_q.size());
    end
  endtask

  task automatic run_pkt(input bit sof, input logic [7:0] pid, input logic [6:0] addr,
                         input logic [3:0] endp, input logic [6:0] len,
                         input logic [10:0] frame);
    logic [7:0] pay[$];
    logic [10:0] fld;
    logic [15:0] c16;
    int cls, n, npop, d0, p0, u0;
    bit start;
    d0 = done_cnt; p0 = pop_cnt; u0 = under_cnt;
    npop = 0;
    start = 1'b1;
    cls = sof ? 1 : ref_class(pid);
    fld = sof ? frame : {endp, addr};
    case (cls)
      0: start = 1'b0;
      1: begin
        exp_q.push_back(sof ? 8'hA5 : pid);
        exp_q.push_back(fld[7:0]);
        exp_q.push_back({ref_crc5(fld), fld[10:8]});
      end
      2: begin
        n = (len > 64) ? 64 : int'(len);
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        c16 = ref_crc16(pay);
        exp_q.push_back(pid);
        foreach (pay[i]) begin
          exp_q.push_back(pay[i]);
          fifo.push_back(pay[i]);
        end
        exp_q.push_back(c16[7:0]);
        exp_q.push_back(c16[15:8]);
        npop = n;
      end
      default: exp_q.push_back(pid);
    endcase
    issue(sof, !sof, pid, addr, endp, len, frame, start);
    wait_idle("rand");
    check("rand_done", done_cnt - d0, start ? 1 : 0);
    check("rand_pops", pop_cnt - p0, npop);
    check("rand_underrun", under_cnt - u0, 0);
    check("rand_fifo_left", fifo.size(), 0);
  endtask

  initial begin
    int d0, p0, u0, o0, kind;
    logic [7:0] pid;
    rst = 1'b1;
    PID = 8'h00; device_address = 7'h00; endpoint_address = 4'h0; data_length = 7'h00;
    PID_ready = 1'b0; send_SOF_packet = 1'b0; frame_num_SIE = 11'h000;
    repeat (3) @(posedge SIE_clk);
    #1;
    check("rst_valid", utmi_tx_valid, 1'b0);
    check("rst_data", utmi_tx_data, 8'h00);
    check("rst_r_en", tx_fifo_r_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_underrun", tx_underrun, 1'b0);
    check("rst_overrun", req_overrun, 1'b0);
    rst = 1'b0;

    // SETUP addr 0 endp 0
    d0 = done_cnt;
    push_hex(128'h2D0010, 3);
    issue(0, 1, 8'h2D, 7'h00, 4'h0, 7'd0, 11'h0, 1);
    wait_idle("setup");
    check("setup_done", done_cnt - d0, 1);

    // DATA0 length 8 with a request arriving mid-packet
    d0 = done_cnt; p0 = pop_cnt; o0 = ovr_cnt;
    fifo = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    push_hex(128'hC3_80060001_00004000_DD94, 11);
    issue(0, 1, 8'hC3, 7'h00, 4'h0, 7'd8, 11'h0, 1);
    @(posedge SIE_clk); #1;
    PID = 8'h2D; PID_ready = 1'b1;
    @(posedge SIE_clk); #1;
    PID_ready = 1'b0;
    wait_idle("data0");
    check("data0_done", done_cnt - d0, 1);
    check("data0_pops", pop_cnt - p0, 8);
    check("data0_overrun", ovr_cnt - o0, 1);
    check("data0_fifo_empty", fifo.size(), 0);

    // DATA1 zero length
    d0 = done_cnt; p0 = pop_cnt;
    push_hex(128'h4B0000, 3);
    issue(0, 1, 8'h4B, 7'h00, 4'h0, 7'd0, 11'h0, 1);
    wait_idle("data1_zlp");
    check("zlp_done", done_cnt - d0, 1);
    check("zlp_pops", pop_cnt - p0, 0);

    // ACK with toggling ready, then a PID with a bad check nibble
    rdy_mode = 1;
    d0 = done_cnt;
    push_hex(128'hD2, 1);
    issue(0, 1, 8'hD2, 7'h00, 4'h0, 7'd0, 11'h0, 1);
    wait_idle("ack");
    check("ack_done", done_cnt - d0, 1);
    d0 = done_cnt;
    issue(0, 1, 8'h33, 7'h00, 4'h0, 7'd0, 11'h0, 0);
    repeat (6) @(posedge SIE_clk);
    #1;
    check("bad_pid_done", done_cnt - d0, 0);
    check("bad_pid_busy", busy, 1'b0);
    rdy_mode = 0;

    // Underrun: length 4 with only two bytes queued
    d0 = done_cnt; p0 = pop_cnt; u0 = under_cnt;
    fifo = '{8'h11, 8'h22};
    push_hex(128'hC31122, 3);
    issue(0, 1, 8'hC3, 7'h00, 4'h0, 7'd4, 11'h0, 1);
    wait_idle("underrun");
    check("underrun_pulse", under_cnt - u0, 1);
    check("underrun_no_done", done_cnt - d0, 0);
    check("underrun_pops", pop_cnt - p0, 2);

    // SOF and PID together, then reset mid-SOF
    o0 = ovr_cnt; d0 = done_cnt;
    push_hex(128'hA5, 1);
    issue(1, 1, 8'h2D, 7'h00, 4'h0, 7'd0, 11'h000, 1);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      @(posedge SIE_clk);
      #1;
    end
    check("sof_pid_sent", exp_q.size(), 0);
    check("sof_overrun", ovr_cnt - o0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", utmi_tx_valid, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge SIE_clk);
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_data", utmi_tx_data, 8'h00);
    check("rst_mid_r_en", tx_fifo_r_en, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge SIE_clk);
    #1;
    check("post_rst_valid", utmi_tx_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_no_done", done_cnt - d0, 0);

    // Randomized requests with random backpressure
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          case ($urandom_range(0, 2)) 0: pid = 8'hE1; 1: pid = 8'h69; default: pid = 8'h2D; endcase
        end
        1: pid = ($urandom_range(0, 1) != 0) ? 8'hC3 : 8'h4B;
        2: begin
          case ($urandom_range(0, 2)) 0: pid = 8'hD2; 1: pid = 8'h5A; default: pid = 8'h1E; endcase
        end
        default: pid = 8'($urandom);
      endcase
      run_pkt(kind == 3, pid, 7'($urandom), 4'($urandom), 7'($urandom_range(0, 90)),
              11'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sie_tx_packetizer.md
# sie_tx_packetizer

Transmit-side packet builder of the SIE, directly downstream of the UHCI controller top. It consumes token/handshake requests (PID, device/endpoint address), SOF requests (frame number) and data-packet payload from the controller's TX FIFO, and emits a byte stream to the UTMI transmit interface. It appends CRC5 to tokens and CRC16 to data packets. It runs entirely in the SIE clock domain.

## Interface
Parameters:
- MAX_PAYLOAD, 64, largest data payload in bytes; `data_length` values above this are clamped to it.

Ports:
- SIE_clk  in  1  SIE clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- PID  in  8  full PID byte, check nibble included; sampled when `PID_ready`=1.
- device_address  in  7  token address field.
- endpoint_address  in  4  token endpoint field.
- data_length  in  7  payload byte count for DATA0/DATA1 packets.
- PID_ready  in  1  single-cycle request to send the packet described by `PID`.
- send_SOF_packet  in  1  single-cycle request to send an SOF packet.
- frame_num_SIE  in  11  SOF frame number; sampled with `send_SOF_packet`.
- tx_sie_data  in  8  TX FIFO head, show-ahead; valid whenever `tx_fifo_empty`=0.
- tx_fifo_empty  in  1  TX FIFO empty.
- tx_fifo_r_en  out  1  pops the TX FIFO head.
- utmi_tx_data  out  8  transmit byte.
- utmi_tx_valid  out  1  UTMI TxValid.
- utmi_tx_ready  in  1  UTMI TxReady; a byte is accepted when valid&&ready.
- busy  out  1  packet in progress.
- tx_done  out  1  one-cycle pulse when a packet completes.
- tx_underrun  out  1  one-cycle pulse when a packet is aborted for an empty FIFO.
- req_overrun  out  1  one-cycle pulse when a request arrives while busy.

## Operation
- Packet class is decoded from `PID[3:0]`:
  - token: 0001 OUT, 1001 IN, 1101 SETUP;
  - data: 0011 DATA0, 1011 DATA1;
  - handshake: 0010 ACK, 1010 NAK, 1110 STALL.
- Any other PID, or a PID whose `PID[7:4]` != ~`PID[3:0]`, is ignored and produces no output.
- SOF request: PID byte 0xA5; 11-bit field is `frame_num_SIE`.
- All request fields are latched in IDLE. Later changes on the inputs have no effect on the packet in progress.
- If `send_SOF_packet` and `PID_ready` are both asserted in IDLE, the SOF is sent and the PID request is dropped with `req_overrun`=1.
- Any request while busy is dropped and pulses `req_overrun`.
- FSM states: IDLE, PID, TOK1, TOK2, DATA, CRC_LO, CRC_HI, DONE. Transitions by class:
  - token/SOF: PID→TOK1→TOK2→DONE;
  - handshake: PID→DONE;
  - data: PID→DATA (repeated, length clamped to MAX_PAYLOAD)→CRC_LO→CRC_HI→DONE;
  - zero-length data: PID→CRC_LO.
- Token field layout: 16 bits = {crc5, endp[3:0], addr[6:0]}. TOK1 sends bits 7:0; TOK2 sends bits 15:8. For SOF the field is {crc5, frame[10:0]}.
- CRC5 rules:
  - polynomial x^5+x^2+1 (reflected 0x14), init 5'h1F;
  - the 11 field bits are processed LSB-first; the result is inverted.
- CRC16 rules:
  - polynomial 0x8005 (reflected 0xA001), init 16'hFFFF, over payload bytes LSB-first;
  - the result is inverted; CRC_LO sends bits 7:0 and CRC_HI sends bits 15:8.
- CRC16 is updated byte-wise on each accepted payload byte.
- DATA state:
  - `utmi_tx_data`=`tx_sie_data`;
  - `utmi_tx_valid`=1 while the FIFO is non-empty;
  - `tx_fifo_r_en`=valid&&ready, so exactly one pop per accepted byte.
- Underrun: if `tx_fifo_empty`=1 in DATA, the FSM drops `utmi_tx_valid` in that same cycle, pulses `tx_underrun`, and returns to IDLE without `tx_done`. Remaining payload is left in the FIFO.

## Timing
- Reset values: `utmi_tx_valid`=0, `utmi_tx_data`=0, `tx_fifo_r_en`=0, `busy`=0, `tx_done`=0, `tx_underrun`=0, `req_overrun`=0, state IDLE, CRC registers at their init values.
- Asserting `rst` mid-packet drops `utmi_tx_valid` asynchronously. No FIFO pop occurs after reset.
- Request latency: a request accepted at edge N gives `busy`=1 and `utmi_tx_valid`=1 with the PID byte after edge N.
- The bytes of a packet are presented back-to-back. The FSM advances one byte per cycle in which valid&&ready=1 and holds otherwise.
- `utmi_tx_valid` stays high continuously from the PID byte to the last byte, except on underrun.
- DONE state, entered on acceptance of the last byte:
  - `tx_done`=1 and `utmi_tx_valid`=0 for exactly one cycle;
  - `busy` stays 1 during DONE, then returns to 0 in IDLE.
- New requests are accepted from IDLE only. Minimum request spacing is packet length + 2 cycles.

## Test plan
- SETUP, addr 0, endp 0, `utmi_tx_ready` held high -> bytes 2D 00 10 on consecutive cycles, then one `tx_done` pulse.
- DATA0, length 8, FIFO preloaded with 80 06 00 01 00 00 40 00 -> bytes C3 80 06 00 01 00 00 40 00 DD 94; 8 pops; FIFO empty afterwards.
- DATA1, length 0 -> bytes 4B 00 00; `tx_fifo_r_en` never asserted.
- ACK (0xD2) with `utmi_tx_ready` toggling 1/0 -> single byte D2 held until accepted, then `tx_done`; a PID 0x33 (bad check nibble) produces no output.
- DATA0, length 4, only 2 bytes in FIFO -> C3 b0 b1, then `utmi_tx_valid` drops with one `tx_underrun` pulse and no `tx_done`.
- Simultaneous `send_SOF_packet` (frame 0x000) and `PID_ready`, then `rst` asserted mid-SOF -> SOF sent starting A5 with `req_overrun` pulse; after reset all outputs are 0 and state is IDLE.
